// File: rtl/tron_pkg.sv
// Shared types, direction codes and small helpers for the light-cycle game sequencer.
package tron_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_OVER = 3'd3,
    MATCH_OVER = 3'd4
  } game_state_t;

  localparam logic [3:0] Y_DEC = 4'b0001;
  localparam logic [3:0] Y_INC = 4'b0010;
  localparam logic [3:0] X_DEC = 4'b0100;
  localparam logic [3:0] X_INC = 4'b1000;
  localparam logic [3:0] NONE  = 4'b0000;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic is_reverse(input logic [3:0] a, input logic [3:0] b);
    return ((a == Y_DEC) && (b == Y_INC)) || ((a == Y_INC) && (b == Y_DEC)) ||
           ((a == X_DEC) && (b == X_INC)) || ((a == X_INC) && (b == X_DEC));
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != NONE) && ((v & (v - 4'd1)) == NONE);
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] s);
    return (s == 2'd3) ? 2'd3 : (s + 2'd1);
  endfunction

  // A count of one still needs a one-bit register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dir_latch.sv
// One player's steering: pending direction from the buttons, committed direction
// updated only at step boundaries so a player can never turn straight back.
module dir_latch
  import tron_pkg::*;
#(
  parameter logic [3:0] RESET_DIR = Y_DEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_init,
  input  logic [3:0] init_dir,
  input  logic [3:0] btn,
  input  logic       commit,
  output logic [3:0] dir
);

  logic [3:0] dir_q, dir_d;
  logic [3:0] pend_q, pend_d;

  // Next committed/pending direction; commit wins over a same-cycle button capture.
  always_comb begin
    dir_d  = dir_q;
    pend_d = pend_q;
    if (load_init) begin
      dir_d  = init_dir;
      pend_d = NONE;
    end else if (commit) begin
      if (pend_q != NONE) begin
        dir_d = pend_q;
      end else begin
        dir_d = dir_q;
      end
      pend_d = NONE;
    end else if (is_onehot4(btn) && !is_reverse(btn, dir_q)) begin
      pend_d = btn;
    end else begin
      pend_d = pend_q;
    end
  end

  // Direction registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_q  <= RESET_DIR;
      pend_q <= NONE;
    end else begin
      dir_q  <= dir_d;
      pend_q <= pend_d;
    end
  end

  assign dir = dir_q;

endmodule

// File: rtl/game_sequencer.sv
// Match/round sequencer for a two-player light-cycle game: countdown, timed movement
// steps, crash scoring and match end, all paced by the per-frame frame_end pulse.
module game_sequencer
  import tron_pkg::*;
#(
  parameter int FRAMES_PER_STEP  = 4,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int OVER_FRAMES      = 120,
  parameter int WIN_SCORE        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_end,
  input  logic        start,
  input  logic [3:0]  p1_btn,
  input  logic [3:0]  p2_btn,
  input  logic        p1_crash,
  input  logic        p2_crash,
  output logic        dflt,
  output logic [3:0]  p1_info,
  output logic [3:0]  p2_info,
  output game_state_t state,
  output logic [1:0]  p1_score,
  output logic [1:0]  p2_score,
  output logic [1:0]  winner
);

  localparam int STEP_W = cnt_w(FRAMES_PER_STEP);
  localparam int CD_W   = cnt_w(COUNTDOWN_FRAMES);
  localparam int OV_W   = cnt_w(OVER_FRAMES);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [OV_W-1:0]   OV_LAST   = OV_W'(OVER_FRAMES - 1);
  localparam logic [1:0]        WIN_PTS   = 2'(WIN_SCORE);

  game_state_t       state_q, state_d;
  logic              start_q, armed_q;
  logic [1:0]        p1_score_q, p1_score_d;
  logic [1:0]        p2_score_q, p2_score_d;
  logic [1:0]        winner_q, winner_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
  logic [OV_W-1:0]   ov_cnt_q, ov_cnt_d;

  logic       start_edge;
  logic       step_frame;
  logic       commit;
  logic       load_init;
  logic [3:0] p1_dir, p2_dir;

  // armed_q masks the first cycle after reset so a held start is not an edge.
  assign start_edge = start & ~start_q & armed_q;
  assign step_frame = (state_q == PLAY) && (step_cnt_q == STEP_LAST);
  assign commit     = step_frame & frame_end;
  assign load_init  = (state_d == COUNTDOWN) && (state_q != COUNTDOWN);

  // Next-state, scoring and frame counters.
  always_comb begin
    state_d    = state_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    step_cnt_d = step_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    ov_cnt_d   = ov_cnt_q;
    case (state_q)
      IDLE, MATCH_OVER: begin
        if (start_edge) begin
          state_d    = COUNTDOWN;
          p1_score_d = 2'd0;
          p2_score_d = 2'd0;
          winner_d   = WIN_NONE;
        end else begin
          state_d = state_q;
        end
      end
      COUNTDOWN: begin
        if (frame_end) begin
          if (cd_cnt_q == CD_LAST) begin
            state_d = PLAY;
          end else begin
            cd_cnt_d = cd_cnt_q + CD_W'(1);
          end
        end else begin
          cd_cnt_d = cd_cnt_q;
        end
      end
      PLAY: begin
        if (frame_end && (p1_crash || p2_crash)) begin
          state_d = ROUND_OVER;
          if (p1_crash && p2_crash) begin
            winner_d = WIN_DRAW;
          end else if (p1_crash) begin
            winner_d   = WIN_P2;
            p2_score_d = sat_inc2(p2_score_q);
          end else begin
            winner_d   = WIN_P1;
            p1_score_d = sat_inc2(p1_score_q);
          end
        end else if (frame_end) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
          end
        end else begin
          step_cnt_d = step_cnt_q;
        end
      end
      ROUND_OVER: begin
        if (frame_end) begin
          if (ov_cnt_q == OV_LAST) begin
            if ((p1_score_q == WIN_PTS) || (p2_score_q == WIN_PTS)) begin
              state_d = MATCH_OVER;
            end else begin
              state_d = COUNTDOWN;
            end
          end else begin
            ov_cnt_d = ov_cnt_q + OV_W'(1);
          end
        end else begin
          ov_cnt_d = ov_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) begin
      step_cnt_d = '0;
      cd_cnt_d   = '0;
      ov_cnt_d   = '0;
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
      p1_score_q <= 2'd0;
      p2_score_q <= 2'd0;
      winner_q   <= WIN_NONE;
      step_cnt_q <= '0;
      cd_cnt_q   <= '0;
      ov_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      armed_q    <= 1'b1;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      step_cnt_q <= step_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      ov_cnt_q   <= ov_cnt_d;
    end
  end

  dir_latch #(.RESET_DIR(Y_DEC)) u_p1_dir (
    .clock     (clock),
    .reset     (reset),
    .load_init (load_init),
    .init_dir  (Y_DEC),
    .btn       (p1_btn),
    .commit    (commit),
    .dir       (p1_dir)
  );

  dir_latch #(.RESET_DIR(Y_INC)) u_p2_dir (
    .clock     (clock),
    .reset     (reset),
    .load_init (load_init),
    .init_dir  (Y_INC),
    .btn       (p2_btn),
    .commit    (commit),
    .dir       (p2_dir)
  );

  assign state    = state_q;
  assign dflt     = (state_q == IDLE) || (state_q == COUNTDOWN);
  assign p1_info  = step_frame ? p1_dir : NONE;
  assign p2_info  = step_frame ? p2_dir : NONE;
  assign p1_score = p1_score_q;
  assign p2_score = p2_score_q;
  assign winner   = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a frame-level reference model checked every cycle.
module tb_game_sequencer;
  import tron_pkg::*;

  localparam int FPS  = 2;
  localparam int CDF  = 3;
  localparam int OVF  = 2;
  localparam int WINS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_end = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  p1_btn = 4'd0;
  logic [3:0]  p2_btn = 4'd0;
  logic        p1_crash = 1'b0;
  logic        p2_crash = 1'b0;
  logic        dflt;
  logic [3:0]  p1_info, p2_info;
  game_state_t state;
  logic [1:0]  p1_score, p2_score, winner;

  int n_total = 0;
  int n_bad   = 0;

  game_sequencer #(
    .FRAMES_PER_STEP(FPS), .COUNTDOWN_FRAMES(CDF), .OVER_FRAMES(OVF), .WIN_SCORE(WINS)
  ) dut (
    .clock(clk), .reset(reset), .frame_end(frame_end), .start(start),
    .p1_btn(p1_btn), .p2_btn(p2_btn), .p1_crash(p1_crash), .p2_crash(p2_crash),
    .dflt(dflt), .p1_info(p1_info), .p2_info(p2_info), .state(state),
    .p1_score(p1_score), .p2_score(p2_score), .winner(winner)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level game rules) ----------------
  game_state_t m_state = IDLE;
  int m_s1 = 0, m_s2 = 0, m_win = 0;
  int m_frames = 0, m_step = 0;
  int m_dir[2] = '{1, 2};
  int m_pend[2] = '{0, 0};
  bit m_prev_start = 1'b0, m_armed = 1'b0;
  game_state_t m_ns;
  bit m_edge, m_commit;
  int m_b;

  function automatic bit rev_pair(input int a, input int b);
    return (a != b) && (((a | b) == 3) || ((a | b) == 12));
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_state = IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_frames = 0; m_step = 0;
      m_dir = '{1, 2}; m_pend = '{0, 0}; m_prev_start = 1'b0; m_armed = 1'b0;
    end else begin
      m_edge = start && !m_prev_start && m_armed;
      m_prev_start = start;
      m_armed = 1'b1;
      m_commit = (m_state == PLAY) && frame_end && (m_step == FPS - 1);
      m_ns = m_state;
      if ((m_state == IDLE || m_state == MATCH_OVER) && m_edge) begin
        m_ns = COUNTDOWN; m_s1 = 0; m_s2 = 0; m_win = 0;
      end else if (m_state == COUNTDOWN && frame_end) begin
        m_frames++;
        if (m_frames == CDF) m_ns = PLAY;
      end else if (m_state == PLAY && frame_end) begin
        if (p1_crash && p2_crash) begin m_ns = ROUND_OVER; m_win = 3; end
        else if (p1_crash) begin m_ns = ROUND_OVER; m_win = 2; m_s2 = (m_s2 < 3) ? m_s2 + 1 : 3; end
        else if (p2_crash) begin m_ns = ROUND_OVER; m_win = 1; m_s1 = (m_s1 < 3) ? m_s1 + 1 : 3; end
        else m_step = (m_step + 1) % FPS;
      end else if (m_state == ROUND_OVER && frame_end) begin
        m_frames++;
        if (m_frames == OVF) m_ns = (m_s1 == WINS || m_s2 == WINS) ? MATCH_OVER : COUNTDOWN;
      end
      for (int p = 0; p < 2; p++) begin
        m_b = (p == 0) ? int'(p1_btn) : int'(p2_btn);
        if (m_ns == COUNTDOWN && m_state != COUNTDOWN) begin
          m_dir[p] = (p == 0) ? 1 : 2;
          m_pend[p] = 0;
        end else if (m_commit) begin
          if (m_pend[p] != 0) m_dir[p] = m_pend[p];
          m_pend[p] = 0;
        end else if ($countones(m_b[3:0]) == 1 && !rev_pair(m_b, m_dir[p])) begin
          m_pend[p] = m_b;
        end
      end
      if (m_ns != m_state) begin m_frames = 0; m_step = 0; end
      m_state = m_ns;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    bit step_now;
    @(negedge clk);
    step_now = (m_state == PLAY) && (m_step == FPS - 1);
    chk("cmp_state", int'(state), int'(m_state));
    chk("cmp_dflt", int'(dflt), (m_state == IDLE || m_state == COUNTDOWN) ? 1 : 0);
    chk("cmp_p1_info", int'(p1_info), step_now ? m_dir[0] : 0);
    chk("cmp_p2_info", int'(p2_info), step_now ? m_dir[1] : 0);
    chk("cmp_p1_score", int'(p1_score), m_s1);
    chk("cmp_p2_score", int'(p2_score), m_s2);
    chk("cmp_winner", int'(winner), m_win);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic frame();
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic crash_frame(input logic c1, input logic c2);
    p1_crash = c1;
    p2_crash = c2;
    frame();
    p1_crash = 1'b0;
    p2_crash = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_dflt", int'(dflt), 1);
    chk("rst_p1_info", int'(p1_info), 0);
    chk("rst_p2_info", int'(p2_info), 0);
    chk("rst_winner", int'(winner), 0);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    press_start();
    chk("start_countdown", int'(state), 1);
    frames(2);
    chk("cd_dflt_before_third", int'(dflt), 1);
    frame();
    chk("cd_to_play", int'(state), 2);
    chk("play_dflt", int'(dflt), 0);
    chk("play_even_p1_info", int'(p1_info), 0);
    frame();
    chk("play_odd_p1_info", int'(p1_info), 1);
    chk("play_odd_p2_info", int'(p2_info), 2);
    frame();
    chk("play_even2_p1_info", int'(p1_info), 0);

    p1_btn = 4'b0010;
    cyc();
    p1_btn = 4'b0000;
    frames(3);
    chk("reverse_ignored", int'(p1_info), 1);
    p1_btn = 4'b0100;
    p2_btn = 4'b0011;
    cyc();
    p1_btn = 4'b0000;
    chk("pending_not_yet", int'(p1_info), 1);
    frames(2);
    p2_btn = 4'b0000;
    chk("turn_taken", int'(p1_info), 4);
    chk("multi_hot_ignored", int'(p2_info), 2);

    p1_crash = 1'b1;
    cyc();
    p1_crash = 1'b0;
    chk("crash_without_frame", int'(state), 2);
    crash_frame(1'b0, 1'b1);
    chk("p2_crash_state", int'(state), 3);
    chk("p2_crash_p1_score", int'(p1_score), 1);
    chk("p2_crash_winner", int'(winner), 1);
    frames(2);
    chk("over_to_countdown", int'(state), 1);
    chk("over_dflt", int'(dflt), 1);

    p1_crash = 1'b1;
    frames(3);
    p1_crash = 1'b0;
    chk("cd_crash_ignored", int'(p2_score), 0);
    crash_frame(1'b1, 1'b1);
    chk("draw_winner", int'(winner), 3);
    chk("draw_p1_score", int'(p1_score), 1);
    chk("draw_p2_score", int'(p2_score), 0);
    frames(2);
    chk("draw_to_countdown", int'(state), 1);
    frames(3);
    crash_frame(1'b0, 1'b1);
    chk("p1_second_point", int'(p1_score), 2);
    frames(2);
    chk("match_over", int'(state), 4);
    chk("match_over_score", int'(p1_score), 2);
    cyc();
    chk("match_over_hold", int'(state), 4);
    press_start();
    chk("rematch_state", int'(state), 1);
    chk("rematch_score", int'(p1_score), 0);
    chk("rematch_winner", int'(winner), 0);

    frames(3);
    crash_frame(1'b0, 1'b1);
    frames(2);
    frames(3);
    frame();
    chk("pre_reset_play", int'(state), 2);
    chk("pre_reset_score", int'(p1_score), 1);
    #1 reset = 1'b1;
    start = 1'b1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_dflt", int'(dflt), 1);
    chk("async_rst_score", int'(p1_score), 0);
    chk("async_rst_winner", int'(winner), 0);
    chk("async_rst_p1_info", int'(p1_info), 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("held_start_no_edge", int'(state), 0);
    start = 1'b0;
    cyc();
    press_start();
    chk("post_reset_start", int'(state), 1);
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 4: frames per player movement step, minimum 1.
REQ-002 SHALL have parameter COUNTDOWN_FRAMES, default 180: frames spent in COUNTDOWN.
REQ-003 SHALL have parameter OVER_FRAMES, default 120: frames spent in ROUND_OVER.
REQ-004 SHALL have parameter WIN_SCORE, default 3: points that end the match, range 1..3.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clock and reset as named below.
REQ-006 SHALL have port clock, in, 1: system clock.
REQ-007 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-008 SHALL have port frame_end, in, 1: one-cycle pulse at pixel row 599, col 799.
REQ-009 SHALL have port start, in, 1: start button, level input.
REQ-010 SHALL have ports p1_btn and p2_btn, in, 4 each: raw direction buttons, direction codes per REQ-015.
REQ-011 SHALL have ports p1_crash and p2_crash, in, 1 each: collision flags, valid on the frame_end cycle.
REQ-012 SHALL have ports dflt, out, 1, and p1_info and p2_info, out, 4 each: position-reset and per-player step command to the draw datapath.
REQ-013 SHALL have port state, out, 3 (game_state_t), and ports p1_score and p2_score, out, 2 each.
REQ-014 SHALL have port winner, out, 2: result of the last round: 00 none, 01 p1, 10 p2, 11 draw.

Function
REQ-015 SHALL use these direction codes: Y_DEC=0001, Y_INC=0010, X_DEC=0100, X_INC=1000, NONE=0000.
  - Y_DEC and Y_INC are a reverse pair; X_DEC and X_INC are a reverse pair.
REQ-016 SHALL have states IDLE, COUNTDOWN, PLAY, ROUND_OVER, MATCH_OVER.
REQ-017 SHALL detect a start edge as a rising edge of start, compared against a registered copy of start.
REQ-018 IDLE SHALL go to COUNTDOWN on a start edge.
  - Both scores cleared; winner set to 00.
REQ-019 COUNTDOWN SHALL count frame_end pulses and go to PLAY on the COUNTDOWN_FRAMES-th pulse.
REQ-020 dflt SHALL be 1 throughout IDLE and throughout COUNTDOWN, and 0 in every other state.
REQ-021 On COUNTDOWN entry, the committed directions SHALL load p1=Y_DEC, p2=Y_INC, and the pending directions SHALL clear.
REQ-022 Each player's pending direction SHALL capture the button value on any cycle where the value is exactly one-hot and is not the reverse of that player's committed direction.
  - All other button values are ignored.
REQ-023 In PLAY, step_cnt SHALL advance on each frame_end, wrapping from FRAMES_PER_STEP-1 to 0; step_cnt clears on PLAY entry.
REQ-024 pX_info SHALL equal the committed direction while state==PLAY and step_cnt==FRAMES_PER_STEP-1, and NONE otherwise.
  - pX_info is driven from registers only.
REQ-025 On a frame_end with step_cnt==FRAMES_PER_STEP-1, a nonzero pending direction SHALL become committed and the pending direction SHALL clear.
  - The new direction takes effect in the next step frame.
REQ-026 On frame_end in PLAY, the crash flags SHALL resolve the round and the state SHALL go to ROUND_OVER:
  - p1 crash only: p2_score+1, winner=10.
  - p2 crash only: p1_score+1, winner=01.
  - both crash: no score change, winner=11.
REQ-027 Crash flags SHALL be ignored outside PLAY and on cycles without frame_end.
REQ-028 ROUND_OVER SHALL last OVER_FRAMES frame_end pulses.
  - Then MATCH_OVER if either score equals WIN_SCORE, else COUNTDOWN.
REQ-029 MATCH_OVER SHALL hold scores and winner and go to COUNTDOWN on a start edge, clearing scores and winner.
REQ-030 Frame counters SHALL be sized by $clog2 of their parameter and clear on every state entry.
REQ-031 Scores SHALL saturate at 3.

Reset
REQ-032 Asserting reset SHALL force, without waiting for a clock edge: state=IDLE, scores=0, winner=00, counters=0, committed directions p1=Y_DEC and p2=Y_INC, pending directions=NONE, start register=0.
  - Resulting outputs: dflt=1, p1_info=p2_info=0000.
REQ-033 Reset asserted mid-round SHALL abandon the round; the first start edge after release begins a new match.
REQ-034 A start held high through reset release SHALL NOT count as an edge.

Structure
REQ-035 Package tron_pkg SHALL hold game_state_t, the five direction constants, and function is_reverse(a,b).
REQ-036 Sub-module dir_latch SHALL implement REQ-021, REQ-022 and REQ-025 for one player and SHALL be instantiated twice.
  - Ports: clock, reset, load_init, init_dir, btn, commit, dir.

Verification (bench params: FRAMES_PER_STEP=2, COUNTDOWN_FRAMES=3, OVER_FRAMES=2, WIN_SCORE=2)
REQ-037 Start pulse, then 3 frame_end -> dflt=1 until the third pulse, state=PLAY next cycle; p1_info=0001 only in odd PLAY frames, else 0000.
REQ-038 In PLAY with p1 committed Y_DEC: p1_btn=0010 -> ignored; p1_btn=0100 then next step frame_end -> p1_info=0100 in the following step frame.
REQ-039 p2_crash=1 on a PLAY frame_end -> p1_score=1, winner=01, state=ROUND_OVER; after 2 frame_end -> COUNTDOWN with dflt=1.
REQ-040 p1_crash=p2_crash=1 together -> winner=11, scores unchanged; p1 wins two rounds -> MATCH_OVER with p1_score=2; start edge -> scores 0, COUNTDOWN.
REQ-041 Reset asserted between clock edges during PLAY -> state=IDLE, dflt=1, scores=0 immediately; start held through release -> remains IDLE.
